// File: rtl/mem_stage_sram_ctrl_pkg.sv
// mem_stage_sram_ctrl_pkg: shared state encoding, default geometry and counter sizing helper
package mem_stage_sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;
  localparam int SRAM_AW_DEF = 18;
  localparam int DATA_BASE_DEF = 1024;
  localparam int WAIT_STATES_DEF = 1;
  function automatic int cnt_w(input int p);
    return p > 1 ? $clog2(p) : 1;
  endfunction
endpackage

// File: rtl/mem_stage_sram_ctrl_phase_counter.sv
// mem_stage_sram_ctrl_phase_counter: counts 0..P-1 within one SRAM phase, flags the last cycle
module mem_stage_sram_ctrl_phase_counter
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int P = 2,
  localparam int W = cnt_w(P)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == W'(P - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr || (en && tc)) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: splits each 32-bit MEM-stage access into two 16-bit SRAM phases, freezing the pipeline meanwhile
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int SRAM_AW = SRAM_AW_DEF,
  parameter int DATA_BASE = DATA_BASE_DEF,
  parameter int WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_en,
  input  logic               MEM_W_en,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        ST_value,
  output logic               ready,
  output logic [31:0]        read_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);
  localparam int P = WAIT_STATES + 1;
  state_t state;
  logic [cnt_w(P)-1:0] cnt;
  logic tc, req, wr, busy, hi_ph, unused_bits;
  logic [31:0] off;
  logic [15:0] rbuf_lo;
  assign req = MEM_R_en | MEM_W_en;
  assign wr = MEM_W_en;
  assign busy = (state == LO) || (state == HI);
  assign hi_ph = state == HI;
  assign off = ALU_result - 32'(DATA_BASE);
  assign unused_bits = ^{off[31:SRAM_AW+1], off[1:0], cnt};
  assign ready = ~req | (state == DONE);
  assign sram_addr = busy ? {off[SRAM_AW:2], hi_ph} : '0;
  assign sram_dq_out = (busy && wr) ? (hi_ph ? ST_value[31:16] : ST_value[15:0]) : '0;
  assign sram_dq_oe = busy & wr;
  assign sram_we_n = ~(busy & wr);
  mem_stage_sram_ctrl_phase_counter #(.P(P)) u_cnt (
    .clk(clk), .rst(rst), .clr(~busy), .en(busy), .cnt(cnt), .tc(tc)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rbuf_lo <= '0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: if (req) state <= LO;
        LO: if (tc) state <= HI;
        HI: if (tc) state <= DONE;
        default: state <= IDLE;
      endcase
      if (state == LO && tc && !wr) rbuf_lo <= sram_dq_in;
      if (state == HI && tc && !wr) read_data <= {sram_dq_in, rbuf_lo};
    end
endmodule
